cpu_cu: RTL and testbench

Control unit for the 16-bit RISC processor: a Moore state machine that sequences fetch, decode and execute by driving every control input of the CPU execution unit and the memory strobes. It reads back the instruction register contents and the ALU status flags from the execution unit, latches its own copy of the flags, and resolves conditional branches. It sits beside the execution unit inside the CPU top level; the two together form the processor core.

---
 rtl/cpu_cu.sv | 140 ++++++++++++++
 tb/tb_cpu_cu.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cpu_cu.sv
// Control unit for the 16-bit RISC core: Moore FSM sequencing fetch/decode/execute,
// driving datapath controls and memory strobes, with latched ALU flags for branches.
module cpu_cu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        w_en,
    output logic        s_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic        adr_sel,
    output logic        pc_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        ST_RST     = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EX_ALU  = 4'd3,
        ST_EX_LD   = 4'd4,
        ST_EX_ST   = 4'd5,
        ST_EX_BR   = 4'd6,
        ST_EX_JR   = 4'd7,
        ST_HALT    = 4'd8,
        ST_ILLEGAL = 4'd9
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] flags_reg;      // {cf, nf, zf}
    logic       cond_raw;
    logic       branch_taken;

    assign state = state_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // Flags capture only the result of an ALU instruction; other states leave them intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg <= 3'b000;
        end else if (state_reg == ST_EX_ALU) begin
            flags_reg <= {C, N, Z};
        end
    end

    always_comb begin
        cond_raw = 1'b1;
        case (ir[13:12])
            2'b00:   cond_raw = 1'b1;
            2'b01:   cond_raw = flags_reg[0];
            2'b10:   cond_raw = flags_reg[2];
            default: cond_raw = flags_reg[1];
        endcase
    end

    assign branch_taken = cond_raw ^ ir[14];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RST:    state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                case (ir[11:9])
                    3'b000:  state_next = ST_EX_ALU;
                    3'b001:  state_next = ST_EX_LD;
                    3'b010:  state_next = ST_EX_ST;
                    3'b011:  state_next = ST_EX_BR;
                    3'b100:  state_next = ST_EX_JR;
                    3'b111:  state_next = ST_HALT;
                    default: state_next = ST_ILLEGAL;
                endcase
            end
            ST_EX_ALU, ST_EX_LD, ST_EX_ST, ST_EX_BR, ST_EX_JR: state_next = ST_FETCH;
            ST_HALT:    state_next = ST_HALT;
            ST_ILLEGAL: state_next = ST_ILLEGAL;
            default:    state_next = ST_RST;
        endcase
    end

    always_comb begin
        w_en    = 1'b0;
        s_sel   = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        adr_sel = 1'b0;
        pc_sel  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_rd = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_EX_ALU: w_en = 1'b1;
            ST_EX_LD: begin
                adr_sel = 1'b1;
                mem_rd  = 1'b1;
                s_sel   = 1'b1;
                w_en    = 1'b1;
            end
            ST_EX_ST: begin
                adr_sel = 1'b1;
                mem_wr  = 1'b1;
            end
            ST_EX_BR: pc_ld = branch_taken;
            ST_EX_JR: begin
                pc_sel = 1'b1;
                pc_ld  = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            ST_ILLEGAL: begin
                halted  = 1'b1;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_cu.sv
// Directed bench for cpu_cu: walks instructions through fetch/decode/execute and checks
// state code plus the full control vector each cycle against hand-computed values.
module tb_cpu_cu;

    logic        clk;
    logic        reset;
    logic [15:0] ir;
    logic        C, N, Z;
    logic        w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, pc_sel;
    logic        mem_rd, mem_wr, halted, illegal;
    logic [3:0]  state;

    int total = 0;
    int bad   = 0;

    // {w_en,s_sel,pc_ld,pc_inc,ir_ld,adr_sel,pc_sel,mem_rd,mem_wr,halted,illegal}
    localparam logic [10:0] O_NONE  = 11'h000;
    localparam logic [10:0] O_FETCH = 11'h0C8;
    localparam logic [10:0] O_ALU   = 11'h400;
    localparam logic [10:0] O_LD    = 11'h628;
    localparam logic [10:0] O_ST    = 11'h024;
    localparam logic [10:0] O_BR_T  = 11'h100;
    localparam logic [10:0] O_JR    = 11'h110;
    localparam logic [10:0] O_HALT  = 11'h002;
    localparam logic [10:0] O_ILL   = 11'h003;

    logic [10:0] outs;
    assign outs = {w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, pc_sel,
                   mem_rd, mem_wr, halted, illegal};

    cpu_cu dut (
        .clk(clk), .reset(reset), .ir(ir), .C(C), .N(N), .Z(Z),
        .w_en(w_en), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .ir_ld(ir_ld), .adr_sel(adr_sel), .pc_sel(pc_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp_state, input logic [10:0] exp_outs);
        total++;
        assert (state === exp_state) else begin
            bad++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, state, exp_state);
        end
        total++;
        assert (outs === exp_outs) else begin
            bad++;
            $error("FAIL %s outs: observed=%03h expected=%03h", tag, outs, exp_outs);
        end
        $display("step %s: state=%0d outs=%03h", tag, state, outs);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered while in FETCH (1 time unit after the edge); leaves the FSM back in FETCH.
    task automatic run_instr(input string tag, input logic [15:0] ir_val,
                             input logic [3:0] ex_state, input logic [10:0] ex_outs);
        ir = ir_val;
        step();
        check({tag, "/dec"}, 4'd2, O_NONE);
        step();
        check({tag, "/ex"}, ex_state, ex_outs);
        step();
        check({tag, "/fetch"}, 4'd1, O_FETCH);
    endtask

    // Reset asynchronously, hold a few edges, release, and land in FETCH.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "/rst_async"}, 4'd0, O_NONE);
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, "/rst_hold"}, 4'd0, O_NONE);
        end
        reset = 1'b1;
        step();
        check({tag, "/first_fetch"}, 4'd1, O_FETCH);
    endtask

    initial begin
        reset = 1'b0;
        ir    = 16'h0000;
        {C, N, Z} = 3'b000;
        #2;
        do_reset("init");

        // ALU with C/N/Z = 1/0/1, then live flags flipped to expose any use of them.
        {C, N, Z} = 3'b101;
        run_instr("alu1", 16'h3000, 4'd3, O_ALU);
        {C, N, Z} = 3'b010;
        run_instr("beq",    16'h1604, 4'd6, O_BR_T);
        run_instr("bne",    16'h5604, 4'd6, O_NONE);
        run_instr("bcs",    16'h2604, 4'd6, O_BR_T);
        run_instr("bmi",    16'h3604, 4'd6, O_NONE);
        run_instr("bra",    16'h0604, 4'd6, O_BR_T);
        run_instr("bnever", 16'h4604, 4'd6, O_NONE);

        // Second ALU latches 0/1/0; later non-ALU states must not touch the flags.
        run_instr("alu2", 16'h0000, 4'd3, O_ALU);
        {C, N, Z} = 3'b101;
        run_instr("ld",   16'h0200, 4'd4, O_LD);
        run_instr("st",   16'h0400, 4'd5, O_ST);
        run_instr("jr",   16'h0800, 4'd7, O_JR);
        run_instr("bmi2", 16'h3604, 4'd6, O_BR_T);
        run_instr("beq2", 16'h1604, 4'd6, O_NONE);
        run_instr("bcc2", 16'h6604, 4'd6, O_BR_T);

        // Reset during EX_ST: mem_wr must vanish without a clock edge.
        ir = 16'h0400;
        step();
        check("st_mid/dec", 4'd2, O_NONE);
        step();
        check("st_mid/ex", 4'd5, O_ST);
        #2;
        do_reset("st_mid");
        run_instr("bz_after_rst", 16'h1604, 4'd6, O_NONE);

        // Illegal class 101 is absorbing.
        ir = 16'h0A00;
        step();
        check("ill/dec", 4'd2, O_NONE);
        for (int i = 0; i < 11; i++) begin
            step();
            check("ill/hold", 4'd9, O_ILL);
        end
        do_reset("after_ill");

        // Class 110 is also illegal.
        ir = 16'h0C00;
        step();
        check("ill110/dec", 4'd2, O_NONE);
        step();
        check("ill110/ex", 4'd9, O_ILL);
        do_reset("after_ill110");

        // HALT is absorbing.
        ir = 16'h0E00;
        step();
        check("halt/dec", 4'd2, O_NONE);
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt/hold", 4'd8, O_HALT);
        end
        do_reset("after_halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
